logic_unit_scheduler: RTL and testbench

Shares one N-bit bitwise logic unit (AND/OR/XOR/NOT) between two requesters. Arbitrates round-robin, latches the winner's operands, executes the operation, and returns a registered result tagged with the requester ID. The scheduler sits between the two operand sources and the shared gate-level logic datapath, and is the only path into that datapath.

---
 rtl/logic_sched_pkg.sv | 20 ++
 rtl/logic_unit.sv | 23 ++
 rtl/logic_unit_scheduler.sv | 99 +++++++++
 tb/tb_logic_unit_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_sched_pkg.sv
// Shared types and constants for the two-requester logic unit scheduler.
package logic_sched_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned OP_W    = 2;

  typedef enum logic [OP_W-1:0] {
    AND   = 2'b00,
    OR    = 2'b01,
    XOR   = 2'b10,
    NOT_A = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/logic_unit.sv
// Combinational N-bit bitwise unit; NOT_A ignores b.
module logic_unit
  import logic_sched_pkg::*;
#(
  parameter int unsigned N = 6
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  op_e          op,
  output logic [N-1:0] result
);

  always_comb begin
    result = '0;
    unique case (op)
      AND:   result = a & b;
      OR:    result = a | b;
      XOR:   result = a ^ b;
      NOT_A: result = ~a;
    endcase
  end

endmodule

// File: rtl/logic_unit_scheduler.sv
// Round-robin scheduler sharing one logic_unit between two requesters,
// returning a registered, ID-tagged result through a valid/ready handshake.
module logic_unit_scheduler
  import logic_sched_pkg::*;
#(
  parameter int unsigned N = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][OP_W-1:0]    req_op,
  input  logic [NUM_REQ-1:0][N-1:0]       req_a,
  input  logic [NUM_REQ-1:0][N-1:0]       req_b,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_id,
  output logic [N-1:0]                    rsp_result,
  output logic                            rsp_zero,
  output logic                            busy
);

  state_e       state;
  logic         last_grant;
  op_e          lat_op;
  logic [N-1:0] lat_a;
  logic [N-1:0] lat_b;
  logic         lat_id;
  logic [N-1:0] lu_result;
  logic         any_req;
  logic         winner;

  // Arbiter: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    any_req   = |req_valid;
    winner    = req_valid[1];
    if (&req_valid) winner = ~last_grant;
    req_ready = '0;
    if ((state == IDLE) && !rst && any_req) req_ready[winner] = 1'b1;
  end

  logic_unit #(.N(N)) u_logic_unit (
    .a      (lat_a),
    .b      (lat_b),
    .op     (lat_op),
    .result (lu_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_op     <= AND;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            lat_op <= op_e'(req_op[winner]);
            lat_a  <= req_a[winner];
            lat_b  <= req_b[winner];
            lat_id <= winner;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= lu_result;
          rsp_zero   <= (lu_result == '0);
          rsp_id     <= lat_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          // Response stays frozen until the consumer takes it.
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            last_grant <= rsp_id;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Scoreboard bench for logic_unit_scheduler: directed scenarios then random traffic.
module tb_logic_unit_scheduler;

  localparam int unsigned N = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid;
  logic [1:0][1:0]     req_op;
  logic [1:0][N-1:0]   req_a;
  logic [1:0][N-1:0]   req_b;
  logic [1:0]          req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [N-1:0]        rsp_result;
  logic                rsp_zero;
  logic                busy;

  logic_unit_scheduler #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         id;
    logic [N-1:0] res;
    logic         z;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Transaction-level model: 0 = free, 1 = accepted last edge, 2 = response pending.
  int   phase;
  logic last;
  logic cur_id;

  function automatic logic [N-1:0] ref_op(input logic [1:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [1:0] pick(input logic [1:0] v, input logic lg);
    if (v == 2'b11) return lg ? 2'b01 : 2'b10;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic new_req(input int w);
    req_valid[w] = 1'b1;
    req_op[w]    = 2'($urandom_range(3));
    req_a[w]     = N'($urandom);
    req_b[w]     = N'($urandom);
  endtask

  // One cycle: check outputs against the model, then drive the next inputs.
  // mode 0: granted requester drops; 1: random traffic; 2: granted requester re-requests.
  task automatic step(input int mode);
    logic [1:0] exp_rdy;
    int         w;
    @(negedge clk);
    exp_rdy = (phase == 0) ? pick(req_valid, last) : 2'b00;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("busy", 32'(busy), 32'(phase != 0));
    check("rsp_valid", 32'(rsp_valid), 32'(phase == 2));
    if (phase == 0 && exp_rdy != 2'b00) begin
      w = exp_rdy[1] ? 1 : 0;
      exp_q.push_back('{id: 1'(w), res: ref_op(req_op[w], req_a[w], req_b[w]),
                        z: (ref_op(req_op[w], req_a[w], req_b[w]) == '0)});
      cur_id = 1'(w);
      phase  = 1;
    end else if (phase == 1) begin
      phase = 2;
    end else if (phase == 2 && rsp_ready) begin
      phase = 0;
      last  = cur_id;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (exp_rdy[i] && mode != 2) req_valid[i] = 1'b0;
      if (mode == 1) begin
        if (!req_valid[i] && ($urandom_range(2) == 0)) new_req(i);
        else if (req_valid[i] && !exp_rdy[i] && ($urandom_range(15) == 0)) req_valid[i] = 1'b0;
      end
    end
    if (mode == 1) rsp_ready = ($urandom_range(3) != 0);
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    exp_q.delete();
    phase = 0;
    last  = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_result", 32'(rsp_result), 32'd0);
      check("rst_id", 32'(rsp_id), 32'd0);
      check("rst_zero", 32'(rsp_zero), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (4) step(0);
  endtask

  // Monitor: pops on every handshake and checks that a stalled response stays frozen.
  initial begin
    exp_t e;
    exp_t held;
    logic hold_v;
    hold_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("hold_result", 32'(rsp_result), 32'(held.res));
          check("hold_id", 32'(rsp_id), 32'(held.id));
          check("hold_zero", 32'(rsp_zero), 32'(held.z));
        end
        hold_v = 1'b0;
        if (rsp_valid) begin
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("rsp_id", 32'(rsp_id), 32'(e.id));
              check("rsp_result", 32'(rsp_result), 32'(e.res));
              check("rsp_zero", 32'(rsp_zero), 32'(e.z));
            end
          end else begin
            hold_v   = 1'b1;
            held.id  = rsp_id;
            held.res = rsp_result;
            held.z   = rsp_zero;
          end
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = 2'b01;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    apply_reset(3);

    // Single OR request from requester 0.
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    step(0);
    req_valid = 2'b01; req_op[0] = 2'd1; req_a[0] = 6'b001110; req_b[0] = 6'b010100;
    step(0);
    step(0);
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_result", 32'(rsp_result), 32'(6'b011110));
    check("t1_id", 32'(rsp_id), 32'd0);
    check("t1_zero", 32'(rsp_zero), 32'd0);
    drain();

    // Both requesters continuously valid: grants alternate.
    req_op[0] = 2'd0; req_a[0] = 6'b111111; req_b[0] = 6'b101010;
    req_op[1] = 2'd2; req_a[1] = 6'b111111; req_b[1] = 6'b101010;
    req_valid = 2'b11;
    repeat (12) step(2);
    drain();

    // NOT of all-ones from requester 1 gives a zero result.
    req_valid = 2'b10; req_op[1] = 2'd3; req_a[1] = 6'b111111; req_b[1] = N'($urandom);
    step(0);
    step(0);
    check("t3_result", 32'(rsp_result), 32'd0);
    check("t3_zero", 32'(rsp_zero), 32'd1);
    check("t3_id", 32'(rsp_id), 32'd1);
    drain();

    // Consumer stall in RESP while requester 0 waits.
    new_req(0);
    rsp_ready = 1'b0;
    step(0);
    step(0);
    new_req(0);
    repeat (5) step(0);
    rsp_ready = 1'b1;
    step(0);
    step(0);
    drain();

    // Reset while in EXEC discards the transaction and restores priority.
    new_req(0);
    step(0);
    apply_reset(2);
    new_req(0);
    new_req(1);
    step(0);
    drain();

    // Idle-time rsp_ready pulse and a request withdrawn before the grant edge.
    rsp_ready = 1'b1;
    new_req(1);
    #2;
    req_valid = 2'b00;
    step(0);
    rsp_ready = 1'b0;
    repeat (3) step(0);

    // Random traffic.
    repeat (800) step(1);
    drain();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
